tsn_strict_pri_sched: RTL and testbench
=======================================

Name: tsn_strict_pri_sched

Overview:
- Per-port strict-priority grant stage directly downstream of the credit-based-shaper eligibility stage in the txmac scheduling pipeline.
- Takes the eligible-queue bitmap and valid strobe, masks it with TAS gate states, and grants exactly one queue (highest index = highest priority).
- Issues a read request to the crossbar read engine and holds the grant until the frame's last AXIS beat.
- Returns the one-hot grant and its valid strobe to the shaper, which uses them as its scheduling-result inputs.

Parameters:
PORT_FIFO_PRI_NUM, 8, number of priority queues per port
PRI_W, 3, width of encoded priority (log2 PORT_FIFO_PRI_NUM)
TIMEOUT_CYC, 4096, cycles without progress in REQ/XMIT before abort

Ports:
i_clk  in  1  clock
i_rst  in  1  reset, asynchronous, active-high
i_sched_en  in  1  enables new grants
i_queue  in  PORT_FIFO_PRI_NUM  eligible-queue bitmap
i_queue_vld  in  1  i_queue valid strobe
i_gate_open  in  PORT_FIFO_PRI_NUM  TAS gate states (1 = open)
o_sched_rst  out  PORT_FIFO_PRI_NUM  one-hot granted queue
o_sched_rst_vld  out  1  one-cycle grant strobe
o_rd_req  out  1  read request to crossbar read engine
o_rd_pri  out  PRI_W  encoded granted priority
i_rd_ack  in  1  read engine accepted request
i_mac_tx_axis_valid  in  1  tx data beat valid
i_mac_tx_axis_ready  in  1  tx data beat ready
i_mac_tx_axis_last  in  1  last beat of frame
o_busy  out  1  state != IDLE
o_frame_done  out  1  one-cycle pulse on completed frame
o_timeout  out  1  one-cycle pulse on abort
o_timeout_cnt  out  16  saturating abort counter

Behaviour:
- Reset values:
  - All outputs 0.
  - State IDLE.
  - Internal timer 0.
- beat = i_mac_tx_axis_valid & i_mac_tx_axis_ready.
- States and transitions:
  - IDLE: on i_queue_vld & i_sched_en, compute m = i_queue & i_gate_open.
    - If m != 0: register o_sched_rst = one-hot of highest set bit of m, o_rd_pri = its index, o_sched_rst_vld = 1 for one cycle, o_rd_req = 1; go to REQ.
    - Grant latency is 1 cycle from i_queue_vld.
    - If m == 0: stay IDLE, no outputs.
  - REQ: hold o_rd_req, o_rd_pri and o_sched_rst stable until i_rd_ack.
    - On i_rd_ack: deassert o_rd_req next cycle; go to XMIT.
    - If i_rd_ack coincides with beat & last (single-beat frame): go directly to IDLE and pulse o_frame_done.
  - XMIT: on beat & last: pulse o_frame_done, clear o_sched_rst, go to IDLE.
    - Non-last beats keep the state.
- A new grant may be issued in the cycle after returning to IDLE, not in the same cycle as completion.
- i_queue_vld outside IDLE is ignored; it is not queued.
- i_sched_en low:
  - Blocks only new grants in IDLE.
  - A frame in progress completes normally.
- Timer:
  - Cleared on entering REQ and on every beat in XMIT.
  - Increments each cycle in REQ/XMIT.
  - When the timer reaches TIMEOUT_CYC-1: pulse o_timeout, saturating-increment o_timeout_cnt, clear o_rd_req/o_sched_rst, go to IDLE.
  - Beats arriving after an abort are ignored.
- o_timeout_cnt saturates at 16'hFFFF and is cleared only by reset.
- o_sched_rst is always one-hot or zero, never multi-hot.
- Asynchronous reset mid-frame:
  - Returns the block immediately to IDLE with all outputs 0.
  - No o_frame_done or o_timeout pulse is generated.

Test Plan:
- i_queue=8'b0010_0110, i_gate_open=8'hFF, i_queue_vld pulse → next cycle o_sched_rst=8'b0010_0000, o_rd_pri=5, o_sched_rst_vld 1 cycle, o_rd_req=1; ack after 3 cycles → o_rd_req low; 10 beats with last on 10th → o_frame_done pulse, o_busy=0.
- i_queue=8'b1000_0001, i_gate_open=8'b0111_1111 → grant 8'b0000_0001, o_rd_pri=0; i_gate_open=8'h00 → no grant, o_busy stays 0.
- Second i_queue_vld (8'hFF) issued during XMIT → ignored, grant unchanged; i_sched_en=0 mid-frame → frame completes, then a further i_queue_vld yields no grant.
- TIMEOUT_CYC=16, i_rd_ack never asserted → o_timeout pulse 16 cycles after grant, o_timeout_cnt=1, state IDLE; repeat → o_timeout_cnt=2.
- i_rd_ack coincides with a valid/ready/last beat → o_frame_done pulse in that cycle, IDLE next cycle; new i_queue_vld the following cycle is granted.
- i_rst asserted during XMIT → all outputs 0 asynchronously, no o_frame_done; after release the next i_queue_vld is granted normally.

Source files
------------

// File: rtl/tsn_strict_pri_sched.sv
// -----------------------------------------------------------------------------
// tsn_strict_pri_sched
// Per-port strict-priority grant stage. Masks the eligible-queue bitmap from
// the credit-based shaper with the TAS gate states, grants the highest-index
// open queue, issues a read request to the crossbar read engine and holds the
// grant until the last AXIS beat of the frame. A watchdog aborts a grant that
// sees no progress for TIMEOUT_CYC cycles.
//
// Ports:
//   i_clk, i_rst            clock, asynchronous active-high reset
//   i_sched_en              enables new grants (does not stop a frame in flight)
//   i_queue, i_queue_vld    eligible-queue bitmap and its strobe
//   i_gate_open             TAS gate states, 1 = open
//   o_sched_rst(_vld)       one-hot granted queue and one-cycle grant strobe
//   o_rd_req, o_rd_pri      read request and encoded priority to read engine
//   i_rd_ack                read engine accepted the request
//   i_mac_tx_axis_*         tx beat handshake used to track frame progress
//   o_busy                  a grant is outstanding
//   o_frame_done            pulse, asserted during the frame's last beat
//   o_timeout, o_timeout_cnt  abort pulse and saturating abort count
// -----------------------------------------------------------------------------
module tsn_strict_pri_sched #(
  parameter int PORT_FIFO_PRI_NUM = 8,
  parameter int PRI_W             = 3,
  parameter int TIMEOUT_CYC       = 4096
) (
  input  logic                         i_clk,
  input  logic                         i_rst,
  input  logic                         i_sched_en,
  input  logic [PORT_FIFO_PRI_NUM-1:0] i_queue,
  input  logic                         i_queue_vld,
  input  logic [PORT_FIFO_PRI_NUM-1:0] i_gate_open,
  output logic [PORT_FIFO_PRI_NUM-1:0] o_sched_rst,
  output logic                         o_sched_rst_vld,
  output logic                         o_rd_req,
  output logic [PRI_W-1:0]             o_rd_pri,
  input  logic                         i_rd_ack,
  input  logic                         i_mac_tx_axis_valid,
  input  logic                         i_mac_tx_axis_ready,
  input  logic                         i_mac_tx_axis_last,
  output logic                         o_busy,
  output logic                         o_frame_done,
  output logic                         o_timeout,
  output logic [15:0]                  o_timeout_cnt
);

  localparam int TMR_W = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT_CYC - 1);

  typedef enum logic [1:0] {IDLE, REQ, XMIT} state_t;

  state_t                       state, state_nxt;
  logic [TMR_W-1:0]             timer, timer_nxt;
  logic [PORT_FIFO_PRI_NUM-1:0] masked, onehot;
  logic [PRI_W-1:0]             pri_idx;
  logic                         beat, last_beat, tmr_exp, grant;

  logic [PORT_FIFO_PRI_NUM-1:0] sched_rst_nxt;
  logic [PRI_W-1:0]             rd_pri_nxt;
  logic                         sched_vld_nxt, rd_req_nxt, timeout_nxt;
  logic [15:0]                  tcnt_nxt;

  assign beat      = i_mac_tx_axis_valid & i_mac_tx_axis_ready;
  assign last_beat = beat & i_mac_tx_axis_last;
  // >= rather than == so a timer pushed past the limit (ack in the expiry
  // cycle) still trips the watchdog for non power-of-two limits.
  assign tmr_exp   = (timer >= TMR_LAST);
  assign masked    = i_queue & i_gate_open;
  assign grant     = i_queue_vld & i_sched_en & (|masked);
  assign o_busy    = (state != IDLE);

  // Highest set bit wins: later iterations overwrite earlier ones.
  always_comb begin
    onehot  = '0;
    pri_idx = '0;
    for (int i = 0; i < PORT_FIFO_PRI_NUM; i++) begin
      if (masked[i]) begin
        onehot    = '0;
        onehot[i] = 1'b1;
        pri_idx   = PRI_W'(i);
      end
    end
  end

  // State and output registers.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state           <= IDLE;
      timer           <= '0;
      o_sched_rst     <= '0;
      o_sched_rst_vld <= 1'b0;
      o_rd_req        <= 1'b0;
      o_rd_pri        <= '0;
      o_timeout       <= 1'b0;
      o_timeout_cnt   <= '0;
    end else begin
      state           <= state_nxt;
      timer           <= timer_nxt;
      o_sched_rst     <= sched_rst_nxt;
      o_sched_rst_vld <= sched_vld_nxt;
      o_rd_req        <= rd_req_nxt;
      o_rd_pri        <= rd_pri_nxt;
      o_timeout       <= timeout_nxt;
      o_timeout_cnt   <= tcnt_nxt;
    end
  end

  // Next state. Progress (ack / last beat) takes precedence over expiry.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (grant) state_nxt = REQ;
      REQ: begin
        if (i_rd_ack)     state_nxt = last_beat ? IDLE : XMIT;
        else if (tmr_exp) state_nxt = IDLE;
      end
      XMIT: begin
        if (last_beat)    state_nxt = IDLE;
        else if (tmr_exp) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Output / timer next values. o_frame_done is combinational so it marks
  // the completing beat itself; the grant is released at the same edge.
  always_comb begin
    sched_rst_nxt = o_sched_rst;
    rd_pri_nxt    = o_rd_pri;
    sched_vld_nxt = 1'b0;
    rd_req_nxt    = o_rd_req;
    timeout_nxt   = 1'b0;
    tcnt_nxt      = o_timeout_cnt;
    timer_nxt     = timer + 1'b1;
    o_frame_done  = 1'b0;
    case (state)
      IDLE: begin
        timer_nxt = '0;
        if (grant) begin
          sched_rst_nxt = onehot;
          rd_pri_nxt    = pri_idx;
          sched_vld_nxt = 1'b1;
          rd_req_nxt    = 1'b1;
        end
      end
      REQ, XMIT: begin
        if (state == REQ && i_rd_ack) rd_req_nxt = 1'b0;
        if ((state == XMIT || i_rd_ack) && last_beat) begin
          o_frame_done  = 1'b1;
          sched_rst_nxt = '0;
          rd_pri_nxt    = '0;
          rd_req_nxt    = 1'b0;
          timer_nxt     = '0;
        end else if (state == XMIT && beat) begin
          timer_nxt = '0;
        end else if (tmr_exp && !(state == REQ && i_rd_ack)) begin
          timeout_nxt   = 1'b1;
          tcnt_nxt      = (o_timeout_cnt == 16'hFFFF) ? o_timeout_cnt
                                                      : o_timeout_cnt + 16'd1;
          sched_rst_nxt = '0;
          rd_pri_nxt    = '0;
          rd_req_nxt    = 1'b0;
          timer_nxt     = '0;
        end
      end
      default: timer_nxt = '0;
    endcase
  end

endmodule

// File: tb/tb_tsn_strict_pri_sched.sv
module tb_tsn_strict_pri_sched;

  logic       i_clk = 1'b0;
  logic       i_rst = 1'b1;
  logic       i_sched_en = 1'b0;
  logic [7:0] i_queue = '0;
  logic       i_queue_vld = 1'b0;
  logic [7:0] i_gate_open = '0;
  logic [7:0] o_sched_rst;
  logic       o_sched_rst_vld;
  logic       o_rd_req;
  logic [2:0] o_rd_pri;
  logic       i_rd_ack = 1'b0;
  logic       i_mac_tx_axis_valid = 1'b0;
  logic       i_mac_tx_axis_ready = 1'b0;
  logic       i_mac_tx_axis_last = 1'b0;
  logic       o_busy;
  logic       o_frame_done;
  logic       o_timeout;
  logic [15:0] o_timeout_cnt;

  int vectors = 0;
  int miscompares = 0;

  typedef struct packed {
    logic [7:0] oh;
    logic [2:0] pri;
  } grant_t;

  grant_t sb[$];

  tsn_strict_pri_sched #(
    .PORT_FIFO_PRI_NUM(8), .PRI_W(3), .TIMEOUT_CYC(16)
  ) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_sched_en(i_sched_en),
    .i_queue(i_queue), .i_queue_vld(i_queue_vld), .i_gate_open(i_gate_open),
    .o_sched_rst(o_sched_rst), .o_sched_rst_vld(o_sched_rst_vld),
    .o_rd_req(o_rd_req), .o_rd_pri(o_rd_pri), .i_rd_ack(i_rd_ack),
    .i_mac_tx_axis_valid(i_mac_tx_axis_valid),
    .i_mac_tx_axis_ready(i_mac_tx_axis_ready),
    .i_mac_tx_axis_last(i_mac_tx_axis_last),
    .o_busy(o_busy), .o_frame_done(o_frame_done),
    .o_timeout(o_timeout), .o_timeout_cnt(o_timeout_cnt)
  );

  always #5 i_clk = ~i_clk;

  initial begin
    #200us;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge i_clk);
    #1;
  endtask

  function automatic grant_t model(input logic [7:0] q, input logic [7:0] g);
    grant_t     r;
    logic [7:0] m;
    r = '0;
    m = q & g;
    for (int i = 7; i >= 0; i--) begin
      if (m[i]) begin
        r.oh  = 8'd1 << i;
        r.pri = 3'(i);
        break;
      end
    end
    return r;
  endfunction

  // Pulse i_queue_vld for one cycle. expect_idle says whether the bench
  // believes the block is idle and enabled, so a grant is due if m != 0.
  task automatic drive_vld(input string tag, input logic [7:0] q, input logic [7:0] g,
                           input bit expect_idle);
    logic pushed;
    pushed = 1'b0;
    i_queue     = q;
    i_gate_open = g;
    i_queue_vld = 1'b1;
    if (expect_idle && ((q & g) != 8'h00)) begin
      sb.push_back(model(q, g));
      pushed = 1'b1;
    end
    cyc();
    i_queue_vld = 1'b0;
    if (pushed) begin
      grant_t e;
      chk({tag, "_sb_nonempty"}, 32'(sb.size() != 0), 32'd1);
      e = (sb.size() != 0) ? sb.pop_front() : '0;
      chk({tag, "_vld"}, 32'(o_sched_rst_vld), 32'd1);
      chk({tag, "_onehot"}, 32'(o_sched_rst), 32'(e.oh));
      chk({tag, "_pri"}, 32'(o_rd_pri), 32'(e.pri));
      chk({tag, "_rd_req"}, 32'(o_rd_req), 32'd1);
      chk({tag, "_busy"}, 32'(o_busy), 32'd1);
    end else begin
      chk({tag, "_no_vld"}, 32'(o_sched_rst_vld), 32'd0);
    end
  endtask

  task automatic ack_cycle();
    i_rd_ack = 1'b1;
    cyc();
    i_rd_ack = 1'b0;
  endtask

  // n beats, last on the n-th; checks the done pulse during the last beat.
  task automatic beats(input string tag, input int n);
    i_mac_tx_axis_valid = 1'b1;
    i_mac_tx_axis_ready = 1'b1;
    for (int i = 0; i < n; i++) begin
      i_mac_tx_axis_last = (i == n - 1);
      #1;
      chk({tag, "_frame_done"}, 32'(o_frame_done), 32'(i == n - 1));
      @(posedge i_clk);
      #1;
    end
    i_mac_tx_axis_valid = 1'b0;
    i_mac_tx_axis_ready = 1'b0;
    i_mac_tx_axis_last  = 1'b0;
    chk({tag, "_idle"}, 32'(o_busy), 32'd0);
    chk({tag, "_released"}, 32'(o_sched_rst), 32'd0);
  endtask

  initial begin
    int n;

    // reset
    #22;
    chk("rst_sched", 32'(o_sched_rst), 32'd0);
    chk("rst_vld", 32'(o_sched_rst_vld), 32'd0);
    chk("rst_rd_req", 32'(o_rd_req), 32'd0);
    chk("rst_busy", 32'(o_busy), 32'd0);
    chk("rst_tcnt", 32'(o_timeout_cnt), 32'd0);
    @(posedge i_clk);
    #1;
    i_rst = 1'b0;
    i_sched_en = 1'b1;
    cyc();

    // basic grant, delayed ack, 10-beat frame
    drive_vld("t1", 8'b0010_0110, 8'hFF, 1'b1);
    cyc();
    chk("t1_vld_pulse", 32'(o_sched_rst_vld), 32'd0);
    chk("t1_rd_req_hold", 32'(o_rd_req), 32'd1);
    cyc();
    chk("t1_grant_hold", 32'(o_sched_rst), 32'h20);
    ack_cycle();
    chk("t1_rd_req_low", 32'(o_rd_req), 32'd0);
    chk("t1_busy_xmit", 32'(o_busy), 32'd1);
    beats("t1", 10);

    // gate masking picks lower queue; all gates closed gives nothing
    drive_vld("t2", 8'b1000_0001, 8'b0111_1111, 1'b1);
    ack_cycle();
    beats("t2", 2);
    drive_vld("t2_closed", 8'b1000_0001, 8'h00, 1'b1);
    chk("t2_closed_busy", 32'(o_busy), 32'd0);
    cyc();
    chk("t2_closed_busy2", 32'(o_busy), 32'd0);

    // vld during XMIT ignored; sched_en low finishes frame then blocks grants
    drive_vld("t3", 8'b0000_0100, 8'hFF, 1'b1);
    ack_cycle();
    drive_vld("t3_ignored", 8'hFF, 8'hFF, 1'b0);
    chk("t3_grant_unchanged", 32'(o_sched_rst), 32'h04);
    chk("t3_pri_unchanged", 32'(o_rd_pri), 32'd2);
    i_sched_en = 1'b0;
    beats("t3", 3);
    drive_vld("t3_disabled", 8'hFF, 8'hFF, 1'b0);
    chk("t3_disabled_busy", 32'(o_busy), 32'd0);
    i_sched_en = 1'b1;
    cyc();

    // timeout twice, late beat ignored
    for (int r = 1; r <= 2; r++) begin
      drive_vld("t4", 8'h10, 8'hFF, 1'b1);
      n = 0;
      while (!o_timeout && n < 40) begin
        cyc();
        n++;
      end
      chk("t4_latency", 32'(n), 32'd16);
      chk("t4_tcnt", 32'(o_timeout_cnt), 32'(r));
      chk("t4_idle", 32'(o_busy), 32'd0);
      chk("t4_rd_req", 32'(o_rd_req), 32'd0);
      chk("t4_sched", 32'(o_sched_rst), 32'd0);
      i_mac_tx_axis_valid = 1'b1;
      i_mac_tx_axis_ready = 1'b1;
      i_mac_tx_axis_last  = 1'b1;
      #1;
      chk("t4_late_beat", 32'(o_frame_done), 32'd0);
      cyc();
      i_mac_tx_axis_valid = 1'b0;
      i_mac_tx_axis_ready = 1'b0;
      i_mac_tx_axis_last  = 1'b0;
      chk("t4_pulse", 32'(o_timeout), 32'd0);
    end

    // ack coincident with single-beat frame, then immediate regrant
    drive_vld("t5", 8'h08, 8'hFF, 1'b1);
    i_rd_ack = 1'b1;
    i_mac_tx_axis_valid = 1'b1;
    i_mac_tx_axis_ready = 1'b1;
    i_mac_tx_axis_last  = 1'b1;
    #1;
    chk("t5_frame_done", 32'(o_frame_done), 32'd1);
    cyc();
    i_rd_ack = 1'b0;
    i_mac_tx_axis_valid = 1'b0;
    i_mac_tx_axis_ready = 1'b0;
    i_mac_tx_axis_last  = 1'b0;
    chk("t5_idle", 32'(o_busy), 32'd0);
    chk("t5_rd_req", 32'(o_rd_req), 32'd0);
    drive_vld("t5_regrant", 8'h40, 8'hFF, 1'b1);
    ack_cycle();
    beats("t5b", 1);

    // async reset during XMIT
    drive_vld("t6", 8'h80, 8'hFF, 1'b1);
    ack_cycle();
    i_mac_tx_axis_valid = 1'b1;
    i_mac_tx_axis_ready = 1'b1;
    cyc();
    i_mac_tx_axis_last = 1'b1;
    #2;
    i_rst = 1'b1;
    #1;
    chk("t6_sched", 32'(o_sched_rst), 32'd0);
    chk("t6_busy", 32'(o_busy), 32'd0);
    chk("t6_frame_done", 32'(o_frame_done), 32'd0);
    chk("t6_tcnt", 32'(o_timeout_cnt), 32'd0);
    i_mac_tx_axis_valid = 1'b0;
    i_mac_tx_axis_ready = 1'b0;
    i_mac_tx_axis_last  = 1'b0;
    cyc();
    i_rst = 1'b0;
    cyc();
    drive_vld("t6_after", 8'h03, 8'hFF, 1'b1);
    ack_cycle();
    beats("t6b", 2);

    chk("sb_drained", 32'(sb.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
